// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and NZCV flag types for the ALU and its issue controller.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_ORR = 4'd3,
      ALU_EOR = 4'd4,
      ALU_LSL = 4'd5,
      ALU_LSR = 4'd6,
      ALU_ASR = 4'd7
   } alu_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue/retire controller: condition check, APSR update, one-entry writeback.
// Defining ALU_ISSUE_PERF_EN adds perf_retired/perf_condfail counters.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  alu_op_t     req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [3:0]  req_rd,
   input  logic        req_setflags,
   input  logic [3:0]  req_cond,
   output alu_op_t     alu_opcode,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  alu_flags_t  alu_flags,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_we,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output alu_flags_t  apsr
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0] perf_retired,
   output logic [31:0] perf_condfail
`endif
);

   logic       accept;
   logic       retire;
   logic       pass;
   alu_flags_t apsr_next;

   assign req_ready  = !wb_valid || wb_ready;
   assign accept     = req_valid && req_ready;
   assign retire     = wb_valid && wb_ready;

   assign alu_opcode = req_op;
   assign alu_a      = req_a;
   assign alu_b      = req_b;

   // Condition sees the committed APSR, i.e. before this op's own flag update.
   always_comb begin
      pass = 1'b1;
      case (req_cond)
         4'h0:    pass = apsr.z;
         4'h1:    pass = !apsr.z;
         4'h2:    pass = apsr.c;
         4'h3:    pass = !apsr.c;
         4'h4:    pass = apsr.n;
         4'h5:    pass = !apsr.n;
         4'h6:    pass = apsr.v;
         4'h7:    pass = !apsr.v;
         4'h8:    pass = apsr.c && !apsr.z;
         4'h9:    pass = !apsr.c || apsr.z;
         4'hA:    pass = (apsr.n == apsr.v);
         4'hB:    pass = (apsr.n != apsr.v);
         4'hC:    pass = !apsr.z && (apsr.n == apsr.v);
         4'hD:    pass = apsr.z || (apsr.n != apsr.v);
         default: pass = 1'b1;
      endcase
   end

   always_comb begin
      apsr_next   = apsr;
      apsr_next.n = alu_flags.n;
      apsr_next.z = alu_flags.z;
      case (req_op)
         ALU_ADD, ALU_SUB: begin
            apsr_next.c = alu_flags.c;
            apsr_next.v = alu_flags.v;
         end
         // A zero shift amount leaves the carry untouched.
         ALU_LSL, ALU_LSR, ALU_ASR: begin
            if (req_b[4:0] != 5'd0) begin
               apsr_next.c = alu_flags.c;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= 4'd0;
         wb_data  <= 32'd0;
         apsr     <= '0;
      end else begin
         if (accept) begin
            wb_valid <= 1'b1;
            wb_we    <= pass;
            wb_rd    <= req_rd;
            wb_data  <= alu_result;
            if (pass && req_setflags) begin
               apsr <= apsr_next;
            end
         end else if (retire) begin
            wb_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired  <= 32'd0;
         perf_condfail <= 32'd0;
      end else if (retire) begin
         perf_retired <= perf_retired + 32'd1;
         if (!wb_we) begin
            perf_condfail <= perf_condfail + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU and reference model.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   alu_op_t     req_op = ALU_ADD;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [3:0]  req_rd = '0;
   logic        req_setflags = 1'b0;
   logic [3:0]  req_cond = 4'hE;
   alu_op_t     alu_opcode;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   alu_flags_t  alu_flags;
   logic        wb_valid;
   logic        wb_ready = 1'b1;
   logic        wb_we;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   alu_flags_t  apsr;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_condfail;
`endif

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .req_setflags(req_setflags), .req_cond(req_cond),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .apsr(apsr)
`ifdef ALU_ISSUE_PERF_EN
      , .perf_retired(perf_retired), .perf_condfail(perf_condfail)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  rd;
      logic [31:0] data;
      logic [3:0]  apsr;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [3:0]  m_apsr = 4'b0000;
   logic        m_wbv = 1'b0;
   int unsigned m_ret = 0;
   int unsigned m_condfail = 0;

   // Returns {n,z,c,v,result}: the combinational Alu the controller drives.
   function automatic logic [35:0] alu_model(alu_op_t op, logic [31:0] a, logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        c;
      logic        v;
      int          sh;
      r = '0; c = 1'b0; v = 1'b0; sh = int'(b[4:0]);
      case (op)
         ALU_ADD: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0]; c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_SUB: begin
            r = a - b; c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_AND: r = a & b;
         ALU_ORR: r = a | b;
         ALU_EOR: r = a ^ b;
         ALU_LSL: begin
            r = a << sh;
            if (sh != 0) c = a[32-sh];
         end
         ALU_LSR: begin
            r = a >> sh;
            if (sh != 0) c = a[sh-1];
         end
         ALU_ASR: begin
            r = 32'($signed(a) >>> sh);
            if (sh != 0) c = a[sh-1];
         end
         default: r = '0;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_model(alu_opcode, alu_a, alu_b);

   function automatic logic cond_ok(logic [3:0] f, logic [3:0] cond);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the model records what the controller must retire.
   task automatic step(input logic v, input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic s, input logic [3:0] cond, input logic wr);
      logic [35:0] res;
      logic        p;
      logic        arith;
      logic        shift;
      @(posedge clk);
      #1;
      req_valid = v; req_op = op; req_a = a; req_b = b; req_rd = rd;
      req_setflags = s; req_cond = cond; wb_ready = wr;
      #1;
      chk("req_ready", req_ready, !m_wbv || wr);
      if (v && (!m_wbv || wr)) begin
         res = alu_model(op, a, b);
         p = cond_ok(m_apsr, cond);
         if (p && s) begin
            arith = (op == ALU_ADD) || (op == ALU_SUB);
            shift = (op == ALU_LSL) || (op == ALU_LSR) || (op == ALU_ASR);
            m_apsr[3:2] = res[35:34];
            if (arith || (shift && b[4:0] != 5'd0)) m_apsr[1] = res[33];
            if (arith) m_apsr[0] = res[32];
         end
         sb.push_back('{we: p, rd: rd, data: res[31:0], apsr: m_apsr});
         m_wbv = 1'b1;
      end else if (m_wbv && wr) begin
         m_wbv = 1'b0;
      end
   endtask

   task automatic idle(input logic wr);
      step(1'b0, ALU_ADD, 32'd0, 32'd0, 4'd0, 1'b0, 4'hE, wr);
   endtask

   always @(negedge clk) begin
      if (!rst && wb_valid && wb_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_retire", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_we", wb_we, e.we);
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
            chk("apsr", apsr, e.apsr);
            m_ret++;
            if (!e.we) m_condfail++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap_data;
      logic [3:0]  snap_apsr;
      logic [3:0]  snap_rd;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_we", wb_we, 1'b0);
      chk("rst_wb_rd", wb_rd, 4'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_apsr", apsr, 4'b0000);

      step(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1, 1, 4'hE, 1);
      idle(1);
      @(negedge clk);
      chk("ovf_data", wb_data, 32'h8000_0000);
      chk("ovf_we", wb_we, 1'b1);
      chk("ovf_apsr", apsr, 4'b1001);

      step(1, ALU_SUB, 32'd5, 32'd5, 4'd2, 1, 4'hE, 1);
      step(1, ALU_ADD, 32'd1, 32'd2, 4'd3, 0, 4'h0, 1);
      idle(1);
      @(negedge clk);
      chk("eq_we", wb_we, 1'b1);
      chk("eq_data", wb_data, 32'd3);
      step(1, ALU_ADD, 32'd1, 32'd2, 4'd3, 0, 4'h1, 1);
      idle(1);
      @(negedge clk);
      chk("ne_we", wb_we, 1'b0);
      chk("ne_apsr", apsr, 4'b0110);

      step(1, ALU_SUB, 32'd5, 32'd3, 4'd4, 1, 4'hE, 1);
      step(1, ALU_EOR, 32'hF0, 32'hF0, 4'd4, 1, 4'hE, 1);
      idle(1);
      @(negedge clk);
      chk("eor_apsr", apsr, 4'b0110);
      step(1, ALU_LSR, 32'd3, 32'd0, 4'd4, 1, 4'hE, 1);
      step(1, ALU_LSR, 32'd3, 32'd1, 4'd4, 1, 4'hE, 1);
      idle(1);
      @(negedge clk);
      chk("lsr_data", wb_data, 32'd1);
      chk("lsr_apsr", apsr, 4'b0010);

      step(1, ALU_ADD, 32'd10, 32'd20, 4'd5, 1, 4'hE, 1);
      step(1, ALU_SUB, 32'd100, 32'd1, 4'd6, 1, 4'hE, 0);
      @(negedge clk);
      snap_data = wb_data; snap_apsr = apsr; snap_rd = wb_rd;
      chk("stall_ready", req_ready, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1, ALU_SUB, 32'd100, 32'd1, 4'd6, 1, 4'hE, 0);
         @(negedge clk);
         chk("stall_ready", req_ready, 1'b0);
         chk("stall_data", wb_data, snap_data);
         chk("stall_rd", wb_rd, snap_rd);
         chk("stall_apsr", apsr, snap_apsr);
      end
      step(1, ALU_SUB, 32'd100, 32'd1, 4'd6, 1, 4'hE, 1);
      idle(0);
      @(negedge clk);
      chk("release_valid", wb_valid, 1'b1);
      chk("release_rd", wb_rd, 4'd6);

      // Reset with an entry pending and the register file stalled.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      m_apsr = 4'b0000; m_wbv = 1'b0; m_ret = 0; m_condfail = 0;
      @(negedge clk);
      chk("rst2_wb_valid", wb_valid, 1'b0);
      chk("rst2_apsr", apsr, 4'b0000);
`ifdef ALU_ISSUE_PERF_EN
      chk("rst2_perf_retired", perf_retired, 32'd0);
      chk("rst2_perf_condfail", perf_condfail, 32'd0);
`endif

      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         case ($urandom_range(0, 4))
            0: a = 32'h7FFF_FFFF;
            1: a = 32'h8000_0000;
            2: a = 32'($urandom_range(0, 8));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(0, 33));
            1: b = a;
            default: b = $urandom;
         endcase
         step($urandom_range(0, 9) < 8, alu_op_t'($urandom_range(0, 9)), a, b,
              4'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 9) < 7);
      end

      for (int i = 0; i < 5 && (sb.size() != 0 || m_wbv); i++) idle(1);
      idle(1);
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_retired", perf_retired, m_ret);
      chk("perf_condfail", perf_condfail, m_condfail);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
